// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg
// Pipeline register between the decode (ID) stage and the execute (EX) stage.
//
// Every output comes straight from a flop, so nothing on an input reaches an
// output combinationally. On each rising edge the register does one of three
// things, in this priority order:
//   clear : flush, or a normal load with valid_in=0. Every output loads 0, so a
//           bubble never asserts a write, memory, branch or status enable.
//   hold  : freeze without flush. Every output keeps its value, valid_out too.
//   load  : every *_out takes its *_in, and valid_out takes valid_in.
// rst (active low, asynchronous) clears every output at once and blocks all
// updates while it is low.
//
// Ports
//   clk, rst                  clock, async active-low reset
//   flush, freeze             squash into a bubble / stall and hold
//   valid_in                  ID stage is presenting a real instruction
//   WB_EN_in .. imm_in        decoded control bits (1 bit each)
//   EXE_CMD_in                ALU command (4 bits)
//   PC_in, Val_Rn_in, Val_Rm_in   PC+4 and register read values (WORD_W bits)
//   Shift_operand_in          shifter operand field (12 bits)
//   Signed_imm_24_in          branch offset field (24 bits)
//   Dest_in, src1_in, src2_in register numbers (4 bits)
//   C_in                      carry flag sampled at decode
//   *_out, valid_out          registered copies of the matching inputs
// -----------------------------------------------------------------------------
module id_stage_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              B_in,
    input  logic              S_in,
    input  logic              imm_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic [WORD_W-1:0] PC_in,
    input  logic [WORD_W-1:0] Val_Rn_in,
    input  logic [WORD_W-1:0] Val_Rm_in,
    input  logic [11:0]       Shift_operand_in,
    input  logic [23:0]       Signed_imm_24_in,
    input  logic [3:0]        Dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic              C_in,
    output logic              valid_out,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic              B_out,
    output logic              S_out,
    output logic              imm_out,
    output logic [3:0]        EXE_CMD_out,
    output logic [WORD_W-1:0] PC_out,
    output logic [WORD_W-1:0] Val_Rn_out,
    output logic [WORD_W-1:0] Val_Rm_out,
    output logic [11:0]       Shift_operand_out,
    output logic [23:0]       Signed_imm_24_out,
    output logic [3:0]        Dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              C_out
);

    // A flush wins over freeze. An invalid instruction only becomes a bubble
    // when the stage is actually loading; under freeze the held contents stay.
    logic clear_now;
    logic load_now;

    assign clear_now = flush | (~freeze & ~valid_in);
    assign load_now  = ~flush & ~freeze & valid_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out         <= 1'b0;
            WB_EN_out         <= 1'b0;
            MEM_R_EN_out      <= 1'b0;
            MEM_W_EN_out      <= 1'b0;
            B_out             <= 1'b0;
            S_out             <= 1'b0;
            imm_out           <= 1'b0;
            EXE_CMD_out       <= '0;
            PC_out            <= '0;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            Shift_operand_out <= '0;
            Signed_imm_24_out <= '0;
            Dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            C_out             <= 1'b0;
        end else if (clear_now) begin
            valid_out         <= 1'b0;
            WB_EN_out         <= 1'b0;
            MEM_R_EN_out      <= 1'b0;
            MEM_W_EN_out      <= 1'b0;
            B_out             <= 1'b0;
            S_out             <= 1'b0;
            imm_out           <= 1'b0;
            EXE_CMD_out       <= '0;
            PC_out            <= '0;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            Shift_operand_out <= '0;
            Signed_imm_24_out <= '0;
            Dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            C_out             <= 1'b0;
        end else if (load_now) begin
            valid_out         <= 1'b1;
            WB_EN_out         <= WB_EN_in;
            MEM_R_EN_out      <= MEM_R_EN_in;
            MEM_W_EN_out      <= MEM_W_EN_in;
            B_out             <= B_in;
            S_out             <= S_in;
            imm_out           <= imm_in;
            EXE_CMD_out       <= EXE_CMD_in;
            PC_out            <= PC_in;
            Val_Rn_out        <= Val_Rn_in;
            Val_Rm_out        <= Val_Rm_in;
            Shift_operand_out <= Shift_operand_in;
            Signed_imm_24_out <= Signed_imm_24_in;
            Dest_out          <= Dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            C_out             <= C_in;
        end
        // otherwise freeze: every output holds
    end

endmodule
